// File: rtl/ifetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
//   slave  : the queue (consumes fetch returns, produces decode head, stall, count)
//   master : the surrounding pipeline (cache return side + decode side)
// Signals:
//   fetch_valid/fetch_pc/fetch_inst : word returned by the I-cache this cycle
//   fetch_inflight                  : cache holds an accepted, not-yet-returned request
//   fetch_stall                     : hold the fetch stage
//   flush                           : drop everything queued and in flight
//   dec_valid/dec_pc/dec_inst       : head entry offered to decode
//   dec_ready                       : decode takes the head entry this cycle
//   count                           : occupied entries
interface ifetch_queue_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    fetch_valid;
    logic [DATA_WIDTH-1:0]   fetch_pc;
    logic [DATA_WIDTH-1:0]   fetch_inst;
    logic                    fetch_inflight;
    logic                    fetch_stall;
    logic                    flush;
    logic                    dec_valid;
    logic [DATA_WIDTH-1:0]   dec_pc;
    logic [DATA_WIDTH-1:0]   dec_inst;
    logic                    dec_ready;
    logic [$clog2(DEPTH):0]  count;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, fetch_inflight, flush, dec_ready,
        output fetch_stall, dec_valid, dec_pc, dec_inst, count
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, fetch_inflight, flush, dec_ready,
        input  fetch_stall, dec_valid, dec_pc, dec_inst, count
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, inst} between the I-cache
// return path and decode. A flush empties the queue; if a cache request is
// still in flight at the flush, the FSM enters DROP so the stale word that
// returns later is discarded instead of queued.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   q    : ifetch_queue_if.slave (fetch return, decode head, stall, flush, count)
module ifetch_queue #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    typedef enum logic {PASS, DROP} state_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    state_t          state, state_nxt;

    logic full, empty, push, pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Full is taken from the registered count, so a simultaneous pop never
    // makes room for a push in the same cycle.
    assign push = q.fetch_valid & ~full & (state == PASS) & ~q.flush;
    assign pop  = ~empty & q.dec_ready & ~q.flush;

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    // Storage is never observable while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: q.fetch_pc, inst: q.fetch_inst};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PASS;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PASS: if (q.flush && q.fetch_inflight) state_nxt = DROP;
            // A flush while dropping means another stale word may still be
            // coming, so keep waiting; otherwise the first return is the stale one.
            DROP: if (q.flush)            state_nxt = DROP;
                  else if (q.fetch_valid) state_nxt = PASS;
            default: state_nxt = PASS;
        endcase
    end

    // While dropping, the stale word must be allowed to return, so never stall.
    assign q.fetch_stall = (state == PASS) & full;
    assign q.dec_valid   = ~empty;
    assign q.dec_pc      = empty ? '0 : mem[rd_ptr].pc;
    assign q.dec_inst    = empty ? '0 : mem[rd_ptr].inst;
    assign q.count       = cnt;
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ifetch_queue_if #(.DEPTH(8), .DATA_WIDTH(32)) bus ();

    ifetch_queue #(.DEPTH(8), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        infl;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [3:0]  e_count;
        logic        e_stall;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic infl, input logic fl, input logic rdy);
        bus.fetch_valid    = fv;
        bus.fetch_pc       = pc;
        bus.fetch_inst     = inst;
        bus.fetch_inflight = infl;
        bus.flush          = fl;
        bus.dec_ready      = rdy;
    endtask

    // Inputs change at posedge+1 and outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int mcount, pushed, popped;
        logic [31:0] exp_pc;

        vt[0] = '{1'b1, 32'hBFC00000, 32'h24080001, 1'b0, 1'b0, 1'b0,
                  1'b1, 32'hBFC00000, 32'h24080001, 4'd1, 1'b0};
        vt[1] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1,
                  1'b0, 32'h0,        32'h0,        4'd0, 1'b0};
        vt[2] = '{1'b1, 32'hBFC00004, 32'h24080002, 1'b0, 1'b0, 1'b1,
                  1'b1, 32'hBFC00004, 32'h24080002, 4'd1, 1'b0};
        vt[3] = '{1'b1, 32'hBFC00008, 32'h24080003, 1'b0, 1'b0, 1'b1,
                  1'b1, 32'hBFC00008, 32'h24080003, 4'd1, 1'b0};
        vt[4] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0,
                  1'b1, 32'hBFC00008, 32'h24080003, 4'd1, 1'b0};
        vt[5] = '{1'b1, 32'h0000BAD0, 32'h0000BAD1, 1'b0, 1'b1, 1'b1,
                  1'b0, 32'h0,        32'h0,        4'd0, 1'b0};
        vt[6] = '{1'b1, 32'h00000100, 32'h00000200, 1'b0, 1'b0, 1'b0,
                  1'b1, 32'h00000100, 32'h00000200, 4'd1, 1'b0};
        vt[7] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1,
                  1'b0, 32'h0,        32'h0,        4'd0, 1'b0};

        // Reset state
        rst = 1'b1;
        idle();
        #12;
        chk("rst_valid", 64'(bus.dec_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_stall", 64'(bus.fetch_stall), 64'd0);
        chk("rst_pc", 64'(bus.dec_pc), 64'd0);
        rst = 1'b0;
        step();

        // Table: single fill/drain, push+pop, flush without in-flight
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].fv, vt[i].pc, vt[i].inst, vt[i].infl, vt[i].fl, vt[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), 64'(bus.dec_valid), 64'(vt[i].e_valid));
            chk($sformatf("vec%0d_pc", i), 64'(bus.dec_pc), 64'(vt[i].e_pc));
            chk($sformatf("vec%0d_inst", i), 64'(bus.dec_inst), 64'(vt[i].e_inst));
            chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vt[i].e_count));
            chk($sformatf("vec%0d_stall", i), 64'(bus.fetch_stall), 64'(vt[i].e_stall));
        end

        // Full boundary
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hBFC00000 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("full_count", 64'(bus.count), 64'd8);
        chk("full_stall", 64'(bus.fetch_stall), 64'd1);
        chk("full_head", 64'(bus.dec_pc), 64'hBFC00000);
        drive(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        step();
        chk("full_pop_only_count", 64'(bus.count), 64'd7);
        chk("full_pop_only_stall", 64'(bus.fetch_stall), 64'd0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("full_drain%0d_pc", i), 64'(bus.dec_pc), 64'(32'hBFC00000 + 32'(4 * i)));
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            step();
        end
        chk("full_drained_valid", 64'(bus.dec_valid), 64'd0);
        chk("full_drained_count", 64'(bus.count), 64'd0);

        // Wrap-around: 20 pushes, pops while occupancy sits around 3..5
        mcount = 0; pushed = 0; popped = 0;
        exp_pc = 32'h00400000;
        for (int cyc = 0; cyc < 100 && popped < 20; cyc++) begin
            logic fv, rdy;
            fv  = (pushed < 20);
            rdy = (mcount >= 4) || (pushed == 20 && mcount > 0);
            drive(fv, 32'h00400000 + 32'(4 * pushed), 32'(pushed), 1'b0, 1'b0, rdy);
            if (rdy) begin
                chk("wrap_pc", 64'(bus.dec_pc), 64'(exp_pc));
                exp_pc += 32'd4;
                popped++;
                mcount--;
            end
            if (fv) begin
                pushed++;
                mcount++;
            end
            step();
        end
        chk("wrap_popped", 64'(popped), 64'd20);
        chk("wrap_end_count", 64'(bus.count), 64'd0);

        // Flush with a word in flight
        idle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h80000000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("fl_pre_count", 64'(bus.count), 64'd5);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        chk("fl_count", 64'(bus.count), 64'd0);
        chk("fl_valid", 64'(bus.dec_valid), 64'd0);
        drive(1'b1, 32'h80000010, 32'h11, 1'b0, 1'b0, 1'b0);
        step();
        chk("fl_drop_count", 64'(bus.count), 64'd0);
        drive(1'b1, 32'h80001000, 32'h22, 1'b0, 1'b0, 1'b0);
        step();
        chk("fl_keep_count", 64'(bus.count), 64'd1);
        chk("fl_keep_pc", 64'(bus.dec_pc), 64'h80001000);

        // Flush while already dropping stays in DROP
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h90000000, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h90000004, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("drop2_discard_count", 64'(bus.count), 64'd0);
        drive(1'b1, 32'h90000008, 32'h33, 1'b0, 1'b0, 1'b0);
        step();
        chk("drop2_keep_pc", 64'(bus.dec_pc), 64'h90000008);

        // Flush with push+pop together and nothing in flight: count 1 -> 3
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hA0000000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("fpp_pre_count", 64'(bus.count), 64'd3);
        drive(1'b1, 32'hA0000100, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        chk("fpp_count", 64'(bus.count), 64'd0);
        chk("fpp_valid", 64'(bus.dec_valid), 64'd0);
        drive(1'b1, 32'hA0000200, 32'h44, 1'b0, 1'b0, 1'b0);
        step();
        chk("fpp_pass_count", 64'(bus.count), 64'd1);
        chk("fpp_pass_pc", 64'(bus.dec_pc), 64'hA0000200);

        // Asynchronous reset mid-operation (count 1 -> 4, then reset between edges)
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0000000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("arst_pre_count", 64'(bus.count), 64'd4);
        idle();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.dec_valid), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_pc", 64'(bus.dec_pc), 64'd0);
        #1;
        rst = 1'b0;
        drive(1'b1, 32'hD0000000, 32'h55, 1'b0, 1'b0, 1'b0);
        step();
        chk("arst_after_count", 64'(bus.count), 64'd1);
        chk("arst_after_pc", 64'(bus.dec_pc), 64'hD0000000);
        chk("arst_after_inst", 64'(bus.dec_inst), 64'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
